// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 add/subtract coprocessor: command codes,
// field geometry, special encodings and FSM state codes.
package fpu_pkg;
    localparam logic [3:0] FPU_ADD = 4'd0;
    localparam logic [3:0] FPU_SUB = 4'd1;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef logic [2:0] fpu_state_t;
    localparam fpu_state_t ST_IDLE   = 3'd0;
    localparam fpu_state_t ST_UNPACK = 3'd1;
    localparam fpu_state_t ST_ALIGN  = 3'd2;
    localparam fpu_state_t ST_ADD    = 3'd3;
    localparam fpu_state_t ST_NORM   = 3'd4;
    localparam fpu_state_t ST_ROUND  = 3'd5;
    localparam fpu_state_t ST_DONE   = 3'd6;
endpackage

// File: rtl/fpu_lzc.sv
// 27-bit leading-zero counter; an all-zero input returns 27.
module fpu_lzc (
    input  logic [26:0] value,
    output logic [4:0]  count
);
    // seen[gi] is set when any bit at or above position gi is one
    logic [26:0] seen;

    genvar gi;
    generate
        for (gi = 0; gi < 27; gi++) begin : g_prefix
            assign seen[gi] = |value[26:gi];
        end
    endgenerate

    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 27; i++) begin
            count = count + {4'd0, ~seen[i]};
        end
    end
endmodule

// File: rtl/fpu_core.sv
// Multi-cycle binary32 add/subtract with round-to-nearest-even, denormal flush
// and request/acknowledge handshakes on both the operand and result sides.
module fpu_core
    import fpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  command,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic        input_rdy,
    output logic        input_ack,
    output logic        output_rdy,
    input  logic        output_ack,
    output logic [31:0] result
);
    fpu_state_t         state_reg;
    logic [3:0]         cmd_reg;
    logic [31:0]        a_reg, b_reg;
    logic               sign_a_reg, sign_b_reg;
    logic [EXP_W-1:0]   exp_a_reg, exp_b_reg, exp_l_reg;
    logic [MAN_W:0]     man_a_reg, man_b_reg;
    logic               special_reg, zero_sign_reg, sign_l_reg, eff_sub_reg, zero_reg;
    logic [31:0]        special_val_reg;
    logic [26:0]        man_l_reg, man_s_reg, norm_reg;
    logic [27:0]        sum_reg;
    logic signed [9:0]  exp_reg;
    logic [MAN_W-1:0]   frac_reg;
    logic               input_ack_reg, output_rdy_reg;
    logic [31:0]        result_reg;

    // Special-operand decode (operands are in a_reg/b_reg during UNPACK)
    logic        sign_b_eff, a_nan, b_nan, a_inf, b_inf, special_next;
    logic [31:0] special_val_next;
    always_comb begin
        sign_b_eff = b_reg[31] ^ (cmd_reg == FPU_SUB);
        a_nan = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
        b_nan = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
        a_inf = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
        b_inf = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
        special_next     = 1'b1;
        special_val_next = QNAN;
        if ((cmd_reg > FPU_SUB) || a_nan || b_nan || (a_inf && b_inf && (a_reg[31] != sign_b_eff))) begin
            special_val_next = QNAN;
        end else if (a_inf) begin
            special_val_next = a_reg[31] ? NEG_INF : POS_INF;
        end else if (b_inf) begin
            special_val_next = sign_b_eff ? NEG_INF : POS_INF;
        end else begin
            special_next = 1'b0;
        end
    end

    // Alignment: larger magnitude first, smaller shifted right with G/R/S
    logic             a_big;
    logic [EXP_W-1:0] exp_big, exp_small, exp_diff;
    logic [MAN_W:0]   man_big, man_small;
    logic [26:0]      ext_small, aligned_next;
    always_comb begin
        a_big     = {exp_a_reg, man_a_reg} >= {exp_b_reg, man_b_reg};
        exp_big   = a_big ? exp_a_reg : exp_b_reg;
        exp_small = a_big ? exp_b_reg : exp_a_reg;
        man_big   = a_big ? man_a_reg : man_b_reg;
        man_small = a_big ? man_b_reg : man_a_reg;
        exp_diff  = exp_big - exp_small;
        ext_small = {man_small, 3'b000};
        if (exp_diff >= 8'd27) begin
            aligned_next = {26'd0, |man_small};
        end else begin
            aligned_next = (ext_small >> exp_diff[4:0])
                         | {26'd0, |(ext_small & ~({27{1'b1}} << exp_diff[4:0]))};
        end
    end

    logic [27:0] sum_next;
    assign sum_next = eff_sub_reg ? ({1'b0, man_l_reg} - {1'b0, man_s_reg})
                                  : ({1'b0, man_l_reg} + {1'b0, man_s_reg});

    logic [4:0] lz_count;
    fpu_lzc u_lzc (
        .value (sum_reg[26:0]),
        .count (lz_count)
    );

    logic [26:0]       norm_next;
    logic signed [9:0] exp_norm_next;
    always_comb begin
        if (sum_reg[27]) begin
            norm_next     = {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            exp_norm_next = $signed({2'b00, exp_l_reg}) + 10'sd1;
        end else begin
            norm_next     = sum_reg[26:0] << lz_count;
            exp_norm_next = $signed({2'b00, exp_l_reg}) - $signed({5'd0, lz_count});
        end
    end

    logic              round_up;
    logic [24:0]       man_rnd;
    logic [MAN_W-1:0]  frac_next;
    logic signed [9:0] exp_rnd_next;
    always_comb begin
        round_up = norm_reg[2] & (norm_reg[1] | norm_reg[0] | norm_reg[3]);
        man_rnd  = {1'b0, norm_reg[26:3]} + {24'd0, round_up};
        if (man_rnd[24]) begin
            frac_next    = man_rnd[23:1];
            exp_rnd_next = exp_reg + 10'sd1;
        end else begin
            frac_next    = man_rnd[22:0];
            exp_rnd_next = exp_reg;
        end
    end

    logic [31:0] pack_next;
    always_comb begin
        if (special_reg) begin
            pack_next = special_val_reg;
        end else if (zero_reg) begin
            pack_next = {zero_sign_reg, 31'd0};
        end else if (exp_reg >= 10'sd255) begin
            pack_next = sign_l_reg ? NEG_INF : POS_INF;
        end else if (exp_reg <= 10'sd0) begin
            pack_next = {sign_l_reg, 31'd0};
        end else begin
            pack_next = {sign_l_reg, exp_reg[7:0], frac_reg};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            input_ack_reg  <= 1'b0;
            output_rdy_reg <= 1'b0;
            result_reg     <= 32'h0;
        end else begin
            case (state_reg)
                ST_IDLE: if (input_rdy) begin
                    cmd_reg       <= command;
                    a_reg         <= data_a;
                    b_reg         <= data_b;
                    input_ack_reg <= 1'b1;
                    state_reg     <= ST_UNPACK;
                end
                ST_UNPACK: begin
                    sign_a_reg      <= a_reg[31];
                    sign_b_reg      <= sign_b_eff;
                    exp_a_reg       <= a_reg[30:23];
                    exp_b_reg       <= b_reg[30:23];
                    man_a_reg       <= (a_reg[30:23] == 8'd0) ? 24'd0 : {1'b1, a_reg[22:0]};
                    man_b_reg       <= (b_reg[30:23] == 8'd0) ? 24'd0 : {1'b1, b_reg[22:0]};
                    special_reg     <= special_next;
                    special_val_reg <= special_val_next;
                    zero_sign_reg   <= a_reg[31] & sign_b_eff;
                    state_reg       <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    sign_l_reg  <= a_big ? sign_a_reg : sign_b_reg;
                    eff_sub_reg <= sign_a_reg ^ sign_b_reg;
                    exp_l_reg   <= exp_big;
                    man_l_reg   <= {man_big, 3'b000};
                    man_s_reg   <= aligned_next;
                    state_reg   <= ST_ADD;
                end
                ST_ADD: begin
                    sum_reg   <= sum_next;
                    state_reg <= ST_NORM;
                end
                ST_NORM: begin
                    norm_reg  <= norm_next;
                    exp_reg   <= exp_norm_next;
                    zero_reg  <= (sum_reg == 28'd0);
                    state_reg <= ST_ROUND;
                end
                ST_ROUND: begin
                    frac_reg  <= frac_next;
                    exp_reg   <= exp_rnd_next;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle packs the result; the handshake is open afterwards
                    if (!output_rdy_reg) begin
                        result_reg     <= pack_next;
                        output_rdy_reg <= 1'b1;
                    end else if (output_ack) begin
                        output_rdy_reg <= 1'b0;
                        input_ack_reg  <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign input_ack  = input_ack_reg;
    assign output_rdy = output_rdy_reg;
    assign result     = result_reg;
endmodule

// File: tb/tb_fpu_core.sv
// Directed bench for fpu_core: arithmetic vectors, specials, handshake timing
// and mid-operation reset, each checked against hand-computed values.
module tb_fpu_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  command = 4'd0;
    logic [31:0] data_a = 32'h0;
    logic [31:0] data_b = 32'h0;
    logic        input_rdy = 1'b0;
    logic        output_ack = 1'b0;
    logic        input_ack, output_rdy;
    logic [31:0] result;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    fpu_core dut (
        .clock      (clock),
        .reset      (reset),
        .command    (command),
        .data_a     (data_a),
        .data_b     (data_b),
        .input_rdy  (input_rdy),
        .input_ack  (input_ack),
        .output_rdy (output_rdy),
        .output_ack (output_ack),
        .result     (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        command   = c;
        data_a    = a;
        data_b    = b;
        input_rdy = 1'b1;
        @(posedge clock);
        #1;
        input_rdy = 1'b0;
        check({tag, "_accept_ack"}, {31'd0, input_ack}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp);
        int lat = 0;
        while (output_rdy !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd6);
        check({tag, "_result"}, result, exp);
        check({tag, "_ack_high"}, {31'd0, input_ack}, 32'd1);
        $display("op %s cmd=%0d a=%h b=%h result=%h expected=%h latency=%0d",
                 tag, command, data_a, data_b, result, exp, lat);
    endtask

    task automatic ack_out(input string tag, input logic [31:0] held);
        @(negedge clock);
        output_ack = 1'b1;
        @(posedge clock);
        #1;
        output_ack = 1'b0;
        check({tag, "_rdy_low"}, {31'd0, output_rdy}, 32'd0);
        check({tag, "_ack_low"}, {31'd0, input_ack}, 32'd0);
        check({tag, "_result_hold"}, result, held);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        start_op(tag, c, a, b);
        wait_done(tag, exp);
        ack_out(tag, exp);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_input_ack", {31'd0, input_ack}, 32'd0);
        check("reset_output_rdy", {31'd0, output_rdy}, 32'd0);
        check("reset_result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // 1.0 + 0.1 with round-up, then a long output stall
        start_op("add_1p0_0p1", 4'd0, 32'h3F800000, 32'h3DCCCCCD);
        wait_done("add_1p0_0p1", 32'h3F8CCCCD);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("stall_rdy", {31'd0, output_rdy}, 32'd1);
            check("stall_ack", {31'd0, input_ack}, 32'd1);
            check("stall_result", result, 32'h3F8CCCCD);
        end
        ack_out("add_1p0_0p1", 32'h3F8CCCCD);

        run_op("add_1p5_2p25", 4'd0, 32'h3FC00000, 32'h40100000, 32'h40700000);
        run_op("sub_1_1", 4'd1, 32'h3F800000, 32'h3F800000, 32'h00000000);

        // input_rdy with output_ack in DONE: only the output handshake completes
        start_op("same_edge", 4'd0, 32'h3F800000, 32'h3F800000);
        wait_done("same_edge", 32'h40000000);
        @(negedge clock);
        output_ack = 1'b1;
        input_rdy  = 1'b1;
        command    = 4'd0;
        data_a     = 32'h3FC00000;
        data_b     = 32'h40100000;
        @(posedge clock);
        #1;
        output_ack = 1'b0;
        check("same_edge_ack_low", {31'd0, input_ack}, 32'd0);
        check("same_edge_rdy_low", {31'd0, output_rdy}, 32'd0);
        @(posedge clock);
        #1;
        input_rdy = 1'b0;
        check("same_edge_reaccept", {31'd0, input_ack}, 32'd1);
        wait_done("same_edge_next", 32'h40700000);
        ack_out("same_edge_next", 32'h40700000);

        run_op("overflow", 4'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run_op("inf_minus_inf", 4'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        run_op("nan_plus_1", 4'd0, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
        run_op("invalid_cmd", 4'd7, 32'h3F800000, 32'h3F800000, 32'h7FC00000);
        run_op("inf_plus_1", 4'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000);
        run_op("tie_even_down", 4'd0, 32'h3F800000, 32'h33800000, 32'h3F800000);
        run_op("tie_odd_up", 4'd0, 32'h3F800001, 32'h33800000, 32'h3F800002);
        run_op("sub_normalize", 4'd1, 32'h3FC00000, 32'h3FA00000, 32'h3E800000);
        run_op("neg0_plus_neg0", 4'd0, 32'h80000000, 32'h80000000, 32'h80000000);
        run_op("neg0_minus_pos0", 4'd1, 32'h80000000, 32'h00000000, 32'h80000000);
        run_op("underflow", 4'd1, 32'h00800001, 32'h00800000, 32'h00000000);
        run_op("denorm_flush", 4'd0, 32'h00400000, 32'h00400000, 32'h00000000);
        run_op("one_minus_inf", 4'd1, 32'h3F800000, 32'h7F800000, 32'hFF800000);

        // Reset while the operation sits in ALIGN
        start_op("reset_mid", 4'd0, 32'h3F800000, 32'h3F800000);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("reset_mid_input_ack", {31'd0, input_ack}, 32'd0);
        check("reset_mid_output_rdy", {31'd0, output_rdy}, 32'd0);
        check("reset_mid_result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run_op("after_reset", 4'd0, 32'h3FC00000, 32'h40100000, 32'h40700000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_core.md
# fpu_core

Single-precision (IEEE-754 binary32) floating-point add/subtract unit with a request/acknowledge handshake on both sides. It accepts one operation at a time from a producer, computes `data_a ± data_b` with round-to-nearest-even over a fixed multi-cycle datapath, and holds the result until a consumer acknowledges it. It sits beside the integer core as the arithmetic coprocessor for float instructions.

## Interface
- No parameters; formats are fixed to binary32.
- `clock` in, 1: single clock, all logic on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `command` in, 4: operation code, captured on acceptance. 4'd0 = ADD, 4'd1 = SUB (`a - b`), any other value = invalid.
- `data_a` in, 32: operand A, captured on acceptance.
- `data_b` in, 32: operand B, captured on acceptance.
- `input_rdy` in, 1: producer has valid `command`/operands.
- `input_ack` out, 1: operation accepted; high from acceptance until the result is consumed.
- `output_rdy` out, 1: `result` valid.
- `output_ack` in, 1: consumer has taken `result`.
- `result` out, 32: binary32 result.

## Operation
- FSM states: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: when `input_rdy` is 1, capture the inputs, set `input_ack`, and go to UNPACK. `input_rdy` is ignored outside IDLE.
- UNPACK: split sign/exponent/mantissa and insert the hidden bit. Denormal inputs are flushed to ±0. For SUB, invert B's sign.
- ALIGN: swap the operands so the larger magnitude is first. Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. A shift of 27 or more leaves sticky only.
- ADD: add or subtract the 27-bit extended mantissas according to the effective sign. The result sign is the sign of the larger operand.
- NORM: on carry-out, shift right 1 and increment the exponent, folding the lost bit into sticky. Otherwise left-shift by the leading-zero count and decrement the exponent.
- ROUND: round to nearest, ties to even. Round up when G & (R | S | LSB). A rounding carry renormalizes.
- Overflow (exponent ≥ 255) gives ±inf (0x7F800000 / 0xFF800000). Underflow (exponent ≤ 0) flushes to ±0.
- Exact zero result is +0. The only exception is (−0)+(−0), or (−0)−(+0), which gives −0.
- Specials, resolved in UNPACK and bypassing the arithmetic but keeping the same latency:
  - Any NaN operand, inf − inf, or an invalid command gives 0x7FC00000.
  - inf ± finite gives that inf.
- DONE: `output_rdy` = 1 and `result` is valid. When `output_ack` is 1 at a rising edge, clear `output_rdy` and `input_ack` and return to IDLE.
- `result` holds its last value after the handshake completes.

## Timing
- Reset values: `input_ack` = 0, `output_rdy` = 0, `result` = 32'h0, state IDLE.
- Reset asserted in any state aborts the operation at the next edge, and the outputs take their reset values.
- Acceptance edge is E0. `input_ack` is high after E0.
- `output_rdy` and `result` are valid after E6, a fixed latency of 6 cycles.
- `output_rdy` and `input_ack` are both high from E6 until the edge on which `output_ack` is sampled high. They fall together at that edge.
- `output_ack` is ignored unless the state is DONE.
- Next acceptance happens no earlier than the edge after the return to IDLE. A still-high `input_rdy` then starts a new operation, so the producer must drop `input_rdy` once it sees `input_ack`.
- `input_rdy` and `output_ack` high on the same edge in DONE: only the output handshake completes.

## Structure
- Package `fpu_pkg` holds:
  - command codes (`FPU_ADD` = 0, `FPU_SUB` = 1);
  - field widths (sign 1, exponent 8, mantissa 23) and bias 127;
  - constants `QNAN` = 32'h7FC00000, `POS_INF`, `NEG_INF`;
  - the state enum.
- One sub-module, `fpu_lzc`: a 27-bit leading-zero counter that returns a 5-bit count, used in NORM.
- Everything else stays in one module.

## Test plan
- 1.0 + 0.1: `data_a` = 0x3F800000, `data_b` = 0x3DCCCCCD, command ADD, `input_rdy` high → after 6 cycles `output_rdy` & `input_ack` are both 1 and `result` = 0x3F8CCCCD (round-up case).
- 1.5 + 2.25: 0x3FC00000 + 0x40100000 → 0x40700000. Then SUB 1.0 − 1.0: 0x3F800000 − 0x3F800000 → 0x00000000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- Specials and invalid codes:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - NaN + 1.0 → 0x7FC00000.
  - command 4'd7 → 0x7FC00000.
- Handshake: hold `output_ack` low for 10 cycles → `output_rdy`, `input_ack` and `result` stay stable. Pulse `output_ack` → both outputs low the next cycle, and a new `input_rdy` is accepted one cycle later.
- Reset mid-operation: assert `reset` during ALIGN → the next cycle has `input_ack` = 0, `output_rdy` = 0 and `result` = 0, and the next operation runs normally.
